// File: rtl/sail_mem_pkg.sv
// Shared definitions for the data-memory controller slice.
// Holds the sign_mask encoding, the controller state encoding, the bus width
// and a helper that flags misaligned half/word accesses.
package sail_mem_pkg;

    localparam int unsigned MEM_W = 32;

    // sign_mask[2:0] one-hot size, sign_mask[3] selects zero extension
    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b100;
    localparam int unsigned UNSIGNED_BIT = 3;

    // Controller state encoding
    typedef logic [0:0] ctrl_state_t;
    localparam ctrl_state_t ST_IDLE = 1'b0;
    localparam ctrl_state_t ST_RMW  = 1'b1;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core <-> data-memory controller bus.
// master (core): drives addr, write_data, memwrite, memread, sign_mask;
//                receives read_data, clk_stall, misaligned.
// slave (controller): the mirror image.
interface data_mem_ctrl_if;
    import sail_mem_pkg::*;

    logic [MEM_W-1:0] addr;
    logic [MEM_W-1:0] write_data;
    logic             memwrite;
    logic             memread;
    logic [3:0]       sign_mask;
    logic [MEM_W-1:0] read_data;
    logic             clk_stall;
    logic             misaligned;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, clk_stall, misaligned
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, clk_stall, misaligned
    );

endinterface

// File: rtl/load_align.sv
// Combinational lane selection for loads and byte-enable generation for
// sub-word stores.
// Ports:
//   word      in  32 : raw RAM word
//   offset    in  2  : byte lane offset (addr[1:0])
//   sign_mask in  4  : access format (bit 3 unsigned, [2:0] one-hot size)
//   load_data out 32 : lane aligned to bit 0, sign- or zero-extended
//   byte_en   out 4  : lanes touched by an access of this size/offset
module load_align
    import sail_mem_pkg::*;
(
    input  logic [MEM_W-1:0] word,
    input  logic [1:0]       offset,
    input  logic [3:0]       sign_mask,
    output logic [MEM_W-1:0] load_data,
    output logic [3:0]       byte_en
);

    logic [MEM_W-1:0] lane;
    logic             sext;

    always_comb begin
        lane      = word >> {offset, 3'b000};
        sext      = ~sign_mask[UNSIGNED_BIT];
        load_data = word;
        byte_en   = 4'b1111;
        // Plain case: the registered mask may hold a non-one-hot value when idle.
        case (sign_mask[2:0])
            SZ_BYTE: begin
                load_data = {{24{sext & lane[7]}}, lane[7:0]};
                byte_en   = 4'b0001 << offset;
            end
            SZ_HALF: begin
                load_data = {{16{sext & lane[15]}}, lane[15:0]};
                byte_en   = 4'b0011 << offset;
            end
            default: begin
                load_data = word;
                byte_en   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the execute and MEM stages.
// Owns a single-port synchronous word RAM; loads return aligned, extended data
// one cycle after the request; sub-word stores run read-modify-write and hold
// the pipeline for one cycle with clk_stall.
// Ports:
//   clk   in : core clock
//   reset in : synchronous, active-high
//   bus      : data_mem_ctrl_if.slave (request in, read_data/clk_stall/misaligned out)
module data_mem_ctrl
    import sail_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = ""
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [MEM_W-1:0] mem [DEPTH_WORDS];

    ctrl_state_t      state_q, state_d;
    logic             load_valid_q;
    logic             misaligned_q;
    logic [AW-1:0]    idx_q;
    logic [1:0]       off_q;
    logic [3:0]       mask_q;
    logic [MEM_W-1:0] wdata_q;
    logic [MEM_W-1:0] ram_q;

    logic [AW-1:0]    req_idx;
    logic [1:0]       req_off;
    logic [2:0]       req_size;
    logic             in_rmw;
    logic             accept;
    logic             mis_now;
    logic             word_store;
    logic             sub_store;
    logic             load_ok;
    logic [AW-1:0]    ram_idx;
    logic             ram_we;
    logic [MEM_W-1:0] ram_wdata;
    logic [MEM_W-1:0] store_lanes;
    logic [MEM_W-1:0] merged;
    logic [MEM_W-1:0] aligned;
    logic [3:0]       byte_en;
    logic             unused_addr_bits;

    assign req_idx  = bus.addr[AW+1:2];
    assign req_off  = bus.addr[1:0];
    assign req_size = bus.sign_mask[2:0];
    // Upper address bits alias onto the RAM
    assign unused_addr_bits = ^bus.addr[MEM_W-1:AW+2];

    assign in_rmw     = (state_q == ST_RMW);
    assign accept     = (bus.memread | bus.memwrite) & ~in_rmw;
    assign mis_now    = accept & is_misaligned(req_size, req_off);
    assign word_store = accept & bus.memwrite & ~mis_now & (req_size == SZ_WORD);
    assign sub_store  = accept & bus.memwrite & ~mis_now &
                        ((req_size == SZ_BYTE) | (req_size == SZ_HALF));
    // Simultaneous read and write is a store, so no load data follows
    assign load_ok    = accept & bus.memread & ~bus.memwrite & ~mis_now;

    always_comb begin
        state_d = ST_IDLE;
        if (!in_rmw && sub_store) state_d = ST_RMW;
    end

    // Registered offset/mask serve both the load result and the RMW merge
    load_align u_load_align (
        .word      (ram_q),
        .offset    (off_q),
        .sign_mask (mask_q),
        .load_data (aligned),
        .byte_en   (byte_en)
    );

    assign store_lanes = wdata_q << {off_q, 3'b000};

    always_comb begin
        merged = ram_q;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = store_lanes[8*i +: 8];
        end
    end

    // A reset during RMW drops the pending write
    assign ram_idx   = in_rmw ? idx_q : req_idx;
    assign ram_we    = word_store | (in_rmw & ~reset);
    assign ram_wdata = in_rmw ? merged : bus.write_data;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= ram_wdata;
        ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            off_q   <= req_off;
            mask_q  <= bus.sign_mask;
            wdata_q <= bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= load_ok;
            misaligned_q <= mis_now;
        end
    end

    assign bus.read_data  = load_valid_q ? aligned : '0;
    assign bus.clk_stall  = in_rmw;
    assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam logic [3:0] LB  = 4'b0001;
    localparam logic [3:0] LBU = 4'b1001;
    localparam logic [3:0] LH  = 4'b0010;
    localparam logic [3:0] LHU = 4'b1010;
    localparam logic [3:0] LW  = 4'b0100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(
        .DEPTH_WORDS (1024),
        .INIT_FILE   ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    logic [31:0] exp_rd = 0;
    logic        exp_mis = 0;
    logic        exp_stall = 0;

    // Reference model state: word memory and one pending sub-word store
    logic [31:0] mmem [int];
    bit          pend = 0;
    int          pend_idx;
    int          pend_off;
    int          pend_n;
    logic [31:0] pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("read_data", bus.read_data, exp_rd);
            check("misaligned", {31'd0, bus.misaligned}, {31'd0, exp_mis});
            check("clk_stall", {31'd0, bus.clk_stall}, {31'd0, exp_stall});
        end
    end

    // Apply one cycle of inputs, advance the model, then publish the
    // expectations for the following cycle.
    task automatic drive(input bit rd, input bit wr, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d, input bit rst);
        logic [31:0] nrd, w, v;
        bit nmis, nst, bad;
        int off, idx, nb;
        bus.memread = rd;
        bus.memwrite = wr;
        bus.sign_mask = m;
        bus.addr = a;
        bus.write_data = d;
        reset = rst;
        nrd = 0; nmis = 0; nst = 0;
        nb = (m[2:0] == 3'b001) ? 1 : (m[2:0] == 3'b010) ? 2 : 4;
        off = int'(a % 4);
        idx = int'((a / 4) % 1024);
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            w = mmem[pend_idx];
            for (int b = 0; b < pend_n; b++) w[8*(pend_off+b) +: 8] = pend_data[8*b +: 8];
            mmem[pend_idx] = w;
            pend = 0;
        end else if (rd || wr) begin
            bad = (nb == 2 && off % 2 != 0) || (nb == 4 && off != 0);
            if (bad) begin
                nmis = 1;
            end else if (wr) begin
                if (nb == 4) mmem[idx] = d;
                else begin
                    pend = 1; pend_idx = idx; pend_off = off; pend_n = nb; pend_data = d;
                    nst = 1;
                end
            end else begin
                v = mmem[idx] >> (8 * off);
                if (nb < 4) begin
                    v = v & ((32'd1 << (8 * nb)) - 1);
                    if (!m[3] && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
                end
                nrd = v;
            end
        end
        @(posedge clk);
        #1;
        exp_rd = nrd;
        exp_mis = nmis;
        exp_stall = nst;
    endtask

    task automatic idle(input bit rst);
        drive(0, 0, 4'b0000, 32'h0, 32'h0, rst);
    endtask

    initial begin
        bus.memread = 0; bus.memwrite = 0; bus.sign_mask = 0;
        bus.addr = 0; bus.write_data = 0;
        idle(1);
        check_en = 1;
        idle(1);
        check("reset read_data", bus.read_data, 32'h0);
        check("reset clk_stall", {31'd0, bus.clk_stall}, 32'h0);
        idle(0);

        drive(0, 1, LW, 32'h10, 32'hDEADBEEF, 0);
        check("sw no stall", {31'd0, bus.clk_stall}, 32'h0);
        drive(1, 0, LW, 32'h10, 32'h0, 0);
        check("lw after sw", bus.read_data, 32'hDEADBEEF);

        drive(0, 1, LB, 32'h11, 32'h5A, 0);
        check("sb stall", {31'd0, bus.clk_stall}, 32'h1);
        drive(0, 1, LB, 32'h11, 32'h5A, 0);
        check("sb stall one cycle", {31'd0, bus.clk_stall}, 32'h0);
        drive(1, 0, LW, 32'h10, 32'h0, 0);
        check("lw after sb", bus.read_data, 32'hDEAD5AEF);

        drive(0, 1, LW, 32'h10, 32'hDEADBEEF, 0);
        drive(1, 0, LB, 32'h13, 32'h0, 0);
        check("lb 0x13", bus.read_data, 32'hFFFFFFDE);
        drive(1, 0, LBU, 32'h13, 32'h0, 0);
        check("lbu 0x13", bus.read_data, 32'h000000DE);
        drive(1, 0, LH, 32'h12, 32'h0, 0);
        check("lh 0x12", bus.read_data, 32'hFFFFDEAD);
        drive(1, 0, LHU, 32'h12, 32'h0, 0);
        check("lhu 0x12", bus.read_data, 32'h0000DEAD);
        drive(1, 0, LB, 32'h10, 32'h0, 0);
        check("lb 0x10", bus.read_data, 32'hFFFFFFEF);

        drive(1, 0, LW, 32'h12, 32'h0, 0);
        check("lw mis pulse", {31'd0, bus.misaligned}, 32'h1);
        check("lw mis data", bus.read_data, 32'h0);
        idle(0);
        check("mis one cycle", {31'd0, bus.misaligned}, 32'h0);

        drive(0, 1, LH, 32'h13, 32'hAAAA, 0);
        check("sh mis pulse", {31'd0, bus.misaligned}, 32'h1);
        check("sh mis no stall", {31'd0, bus.clk_stall}, 32'h0);
        drive(1, 0, LW, 32'h10, 32'h0, 0);
        check("lw after mis sh", bus.read_data, 32'hDEADBEEF);

        drive(0, 1, LH, 32'h12, 32'h1234, 0);
        check("sh stall", {31'd0, bus.clk_stall}, 32'h1);
        drive(0, 1, LH, 32'h12, 32'h1234, 1);
        check("reset in rmw", {31'd0, bus.clk_stall}, 32'h0);
        drive(1, 0, LW, 32'h10, 32'h0, 0);
        check("rmw dropped", bus.read_data, 32'hDEADBEEF);

        drive(1, 1, LW, 32'h20, 32'h11112222, 0);
        check("rd+wr data", bus.read_data, 32'h0);
        drive(1, 0, LW, 32'h20, 32'h0, 0);
        check("lw after rd+wr", bus.read_data, 32'h11112222);

        drive(0, 1, LH, 32'h22, 32'hBEEF, 0);
        drive(0, 1, LH, 32'h22, 32'hBEEF, 0);
        drive(1, 0, LW, 32'h20, 32'h0, 0);
        check("lw after sh", bus.read_data, 32'hBEEF2222);
        idle(0);
        idle(0);
        check_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
